wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-stage consumer of the MEM/WB pipeline latch outputs.
- Selects the writeback data (memory load vs ALU result) and commits it to a 32-entry x 32-bit general register file.
- Provides two combinational read ports to the ID stage and a committed-write counter for debug/perf.
- Sits between the MEM/WB latch and the ID stage / forwarding logic in the 5-stage pipeline.

Parameters:
- DATA_W, 32, register and datapath width.
- ADDR_W, 5, register index width; file depth = 2**ADDR_W.
- CNT_W, 32, width of committed-write counter.

Ports:
- clk  input  1  pipeline clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- WB_MemtoReg  input  1  1 = write load data, 0 = write ALU result.
- WB_RegWrite  input  1  register write enable from the MEM/WB latch.
- WB_write_reg  input  ADDR_W  destination register index.
- WB_read_data_mem  input  DATA_W  load data from the MEM/WB latch.
- WB_alu_result  input  DATA_W  ALU result from the MEM/WB latch.
- read_reg1  input  ADDR_W  ID-stage source index A.
- read_reg2  input  ADDR_W  ID-stage source index B.
- read_data1  output  DATA_W  register A value.
- read_data2  output  DATA_W  register B value.
- WB_write_data  output  DATA_W  selected writeback data, combinational, for forwarding to EX.
- commit_count  output  CNT_W  number of committed register writes.

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk, single clock domain.
  - On rst=1, all registers 1..31 and commit_count clear to 0 immediately, without waiting for a clock edge.
  - While rst=1, writes are blocked.
  - Reset asserted mid-operation discards any write on that edge.
- WB_write_data = WB_MemtoReg ? WB_read_data_mem : WB_alu_result. Purely combinational and valid during reset.
- Commit:
  - On a rising clk edge, if rst=0, WB_RegWrite=1 and WB_write_reg!=0, store WB_write_data into regs[WB_write_reg].
  - Write latency is 1 edge.
- Register 0 is hardwired to 0.
  - Writes to index 0 are silently dropped and are not counted.
  - Reads of index 0 always return 0, even when bypass matches.
- Reads are combinational from read_reg1/read_reg2. Both ports may address the same register.
- Read outputs during reset: 0 for every index.
- commit_count:
  - Increments by 1 on each committed write, as defined above.
  - Saturates at 2**CNT_W-1; it never wraps.
  - Not incremented for WB_RegWrite=0 or for index 0.
- X/undefined inputs while WB_RegWrite=0 must not alter state.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - Write-first internal bypass: if WB_RegWrite=1, WB_write_reg!=0 and read_regN==WB_write_reg in the same cycle, read_dataN = WB_write_data; otherwise read_dataN = stored value.
  - Resolves the WB->ID hazard without external forwarding.
- Not defined:
  - read_dataN always returns the stored value.
  - The new value is visible only after the commit edge; the hazard unit must stall or forward.

Test Plan:
- Reset: assert rst mid-cycle after writing r5=0x1234 -> read_data1(r5)=0 and commit_count=0 immediately, with no clock edge required.
- Mux and commit: MemtoReg=1, mem=0xDEADBEEF, alu=0x11, RegWrite=1, reg=7, one edge -> r7=0xDEADBEEF, commit_count=1. Repeat with MemtoReg=0, reg=8 -> r8=0x11, count=2.
- Zero register: RegWrite=1, reg=0, data=0xFFFFFFFF -> read r0=0, count unchanged. RegWrite=0, reg=9 -> r9 unchanged.
- Dual read: r3=0xA, r4=0xB; read_reg1=3, read_reg2=4 -> 0xA/0xB. Both ports =4 -> 0xB/0xB.
- Same-cycle hazard: r10=0x1, write r10<=0x2 with read_reg1=10 before the edge:
  - With WB_BYPASS_EN -> read_data1=0x2.
  - Without -> read_data1=0x1, then 0x2 after the edge.
- Saturation: CNT_W=3, perform 9 committed writes -> commit_count stays at 7 and does not wrap to 0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage: selects load vs ALU data, commits it to a 32x32 register file with r0 hardwired to 0.
// Optional macro WB_BYPASS_EN enables write-first bypass from the writeback port to both read ports.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_MemtoReg,
    input  logic              WB_RegWrite,
    input  logic [ADDR_W-1:0] WB_write_reg,
    input  logic [DATA_W-1:0] WB_read_data_mem,
    input  logic [DATA_W-1:0] WB_alu_result,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] WB_write_data,
    output logic [CNT_W-1:0]  commit_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              commit;

    assign WB_write_data = WB_MemtoReg ? WB_read_data_mem : WB_alu_result;
    assign commit        = WB_RegWrite && (WB_write_reg != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[WB_write_reg] <= WB_write_data;
        end
    end

    // Counter holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_count <= '0;
        end else if (commit && (commit_count != '1)) begin
            commit_count <= commit_count + CNT_W'(1);
        end
    end

    always_comb begin
        read_data1 = regs[read_reg1];
        read_data2 = regs[read_reg2];
`ifdef WB_BYPASS_EN
        if (commit && (read_reg1 == WB_write_reg)) read_data1 = WB_write_data;
        if (commit && (read_reg2 == WB_write_reg)) read_data2 = WB_write_data;
`endif
        // r0 and reset override any stored or bypassed value.
        if (rst || (read_reg1 == '0)) read_data1 = '0;
        if (rst || (read_reg2 == '0)) read_data2 = '0;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; a second CNT_W=3 instance exercises counter saturation.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_MemtoReg;
    logic        WB_RegWrite;
    logic [4:0]  WB_write_reg;
    logic [31:0] WB_read_data_mem;
    logic [31:0] WB_alu_result;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] WB_write_data;
    logic [31:0] commit_count;

    logic [31:0] sat_rd1;
    logic [31:0] sat_rd2;
    logic [31:0] sat_wd;
    logic [2:0]  sat_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
        .WB_write_reg(WB_write_reg), .WB_read_data_mem(WB_read_data_mem),
        .WB_alu_result(WB_alu_result),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .WB_write_data(WB_write_data), .commit_count(commit_count)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(3)) u_sat (
        .clk(clk), .rst(rst),
        .WB_MemtoReg(WB_MemtoReg), .WB_RegWrite(WB_RegWrite),
        .WB_write_reg(WB_write_reg), .WB_read_data_mem(WB_read_data_mem),
        .WB_alu_result(WB_alu_result),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(sat_rd1), .read_data2(sat_rd2),
        .WB_write_data(sat_wd), .commit_count(sat_count)
    );

    // Called just after a rising edge; leaves inputs idle just after the commit edge.
    task automatic do_write(input logic m2r, input logic [4:0] rd,
                            input logic [31:0] mem, input logic [31:0] alu);
        WB_MemtoReg      = m2r;
        WB_write_reg     = rd;
        WB_read_data_mem = mem;
        WB_alu_result    = alu;
        WB_RegWrite      = 1'b1;
        @(posedge clk);
        #1;
        WB_RegWrite      = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        WB_MemtoReg = 1'b0; WB_RegWrite = 1'b0; WB_write_reg = '0;
        WB_read_data_mem = '0; WB_alu_result = '0;
        read_reg1 = 5'd5; read_reg2 = 5'd0;
        #1;
        checks++;
        if (commit_count !== 32'd0) begin
            errors++; $display("FAIL reset_count: got %h expected %h", commit_count, 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        do_write(1'b0, 5'd5, 32'h0, 32'h1234);
        checks++;
        if (read_data1 !== 32'h1234) begin
            errors++; $display("FAIL pre_reset_r5: got %h expected %h", read_data1, 32'h1234);
        end
        checks++;
        if (commit_count !== 32'd1) begin
            errors++; $display("FAIL pre_reset_count: got %h expected %h", commit_count, 32'd1);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++; $display("FAIL async_reset_r5: got %h expected %h", read_data1, 32'h0);
        end
        checks++;
        if (commit_count !== 32'd0) begin
            errors++; $display("FAIL async_reset_count: got %h expected %h", commit_count, 32'd0);
        end
        // A write held across an edge while in reset must be discarded.
        WB_MemtoReg = 1'b1; WB_write_reg = 5'd6; WB_read_data_mem = 32'h55;
        WB_alu_result = 32'h66; WB_RegWrite = 1'b1; read_reg2 = 5'd6;
        #1;
        checks++;
        if (WB_write_data !== 32'h55) begin
            errors++; $display("FAIL wdata_in_reset: got %h expected %h", WB_write_data, 32'h55);
        end
        checks++;
        if (read_data2 !== 32'h0) begin
            errors++; $display("FAIL read_in_reset: got %h expected %h", read_data2, 32'h0);
        end
        @(posedge clk); #1;
        WB_RegWrite = 1'b0;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++;
        if (read_data2 !== 32'h0) begin
            errors++; $display("FAIL blocked_write_r6: got %h expected %h", read_data2, 32'h0);
        end
        checks++;
        if (commit_count !== 32'd0) begin
            errors++; $display("FAIL blocked_write_count: got %h expected %h", commit_count, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mux_commit;
        WB_MemtoReg = 1'b1; WB_read_data_mem = 32'hDEADBEEF; WB_alu_result = 32'h11;
        #1;
        checks++;
        if (WB_write_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mux_mem: got %h expected %h", WB_write_data, 32'hDEADBEEF);
        end
        WB_MemtoReg = 1'b0;
        #1;
        checks++;
        if (WB_write_data !== 32'h11) begin
            errors++; $display("FAIL mux_alu: got %h expected %h", WB_write_data, 32'h11);
        end
        @(posedge clk); #1;
        do_write(1'b1, 5'd7, 32'hDEADBEEF, 32'h11);
        read_reg1 = 5'd7; #1;
        checks++;
        if (read_data1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL commit_r7: got %h expected %h", read_data1, 32'hDEADBEEF);
        end
        checks++;
        if (commit_count !== 32'd1) begin
            errors++; $display("FAIL count_after_r7: got %h expected %h", commit_count, 32'd1);
        end
        do_write(1'b0, 5'd8, 32'hDEADBEEF, 32'h11);
        read_reg2 = 5'd8; #1;
        checks++;
        if (read_data2 !== 32'h11) begin
            errors++; $display("FAIL commit_r8: got %h expected %h", read_data2, 32'h11);
        end
        checks++;
        if (commit_count !== 32'd2) begin
            errors++; $display("FAIL count_after_r8: got %h expected %h", commit_count, 32'd2);
        end
    endtask

    task automatic test_zero_reg;
        read_reg1 = 5'd0;
        WB_MemtoReg = 1'b0; WB_write_reg = 5'd0; WB_alu_result = 32'hFFFFFFFF;
        WB_RegWrite = 1'b1;
        #1;
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++; $display("FAIL r0_during_write: got %h expected %h", read_data1, 32'h0);
        end
        @(posedge clk); #1;
        WB_RegWrite = 1'b0;
        checks++;
        if (read_data1 !== 32'h0) begin
            errors++; $display("FAIL r0_after_write: got %h expected %h", read_data1, 32'h0);
        end
        checks++;
        if (commit_count !== 32'd2) begin
            errors++; $display("FAIL r0_count: got %h expected %h", commit_count, 32'd2);
        end
        // Disabled write with undefined data/select must leave r9 alone.
        WB_write_reg = 5'd9; WB_MemtoReg = 1'bx; WB_read_data_mem = 'x; WB_alu_result = 'x;
        read_reg2 = 5'd9;
        @(posedge clk); #1;
        checks++;
        if (read_data2 !== 32'h0) begin
            errors++; $display("FAIL r9_no_write: got %h expected %h", read_data2, 32'h0);
        end
        checks++;
        if (commit_count !== 32'd2) begin
            errors++; $display("FAIL r9_count: got %h expected %h", commit_count, 32'd2);
        end
    endtask

    task automatic test_dual_read;
        do_write(1'b0, 5'd3, 32'h0, 32'hA);
        do_write(1'b0, 5'd4, 32'h0, 32'hB);
        read_reg1 = 5'd3; read_reg2 = 5'd4; #1;
        checks++;
        if (read_data1 !== 32'hA || read_data2 !== 32'hB) begin
            errors++; $display("FAIL dual_read: got %h/%h expected %h/%h", read_data1, read_data2, 32'hA, 32'hB);
        end
        read_reg1 = 5'd4; #1;
        checks++;
        if (read_data1 !== 32'hB || read_data2 !== 32'hB) begin
            errors++; $display("FAIL same_read: got %h/%h expected %h/%h", read_data1, read_data2, 32'hB, 32'hB);
        end
        checks++;
        if (commit_count !== 32'd4) begin
            errors++; $display("FAIL dual_count: got %h expected %h", commit_count, 32'd4);
        end
    endtask

    task automatic test_hazard;
        logic [31:0] exp_pre;
        do_write(1'b0, 5'd10, 32'h0, 32'h1);
        read_reg1 = 5'd10;
        WB_MemtoReg = 1'b0; WB_write_reg = 5'd10; WB_alu_result = 32'h2; WB_RegWrite = 1'b1;
`ifdef WB_BYPASS_EN
        exp_pre = 32'h2;
`else
        exp_pre = 32'h1;
`endif
        #1;
        checks++;
        if (read_data1 !== exp_pre) begin
            errors++; $display("FAIL hazard_pre_edge: got %h expected %h", read_data1, exp_pre);
        end
        @(posedge clk); #1;
        WB_RegWrite = 1'b0;
        checks++;
        if (read_data1 !== 32'h2) begin
            errors++; $display("FAIL hazard_post_edge: got %h expected %h", read_data1, 32'h2);
        end
        checks++;
        if (commit_count !== 32'd6) begin
            errors++; $display("FAIL hazard_count: got %h expected %h", commit_count, 32'd6);
        end
    endtask

    task automatic test_back_to_back;
        do_write(1'b1, 5'd11, 32'hC0DE0011, 32'h0);
        do_write(1'b0, 5'd12, 32'h0, 32'hC0DE0012);
        do_write(1'b1, 5'd13, 32'hC0DE0013, 32'h0);
        read_reg1 = 5'd11; read_reg2 = 5'd13; #1;
        checks++;
        if (read_data1 !== 32'hC0DE0011 || read_data2 !== 32'hC0DE0013) begin
            errors++; $display("FAIL b2b_r11_r13: got %h/%h expected %h/%h", read_data1, read_data2, 32'hC0DE0011, 32'hC0DE0013);
        end
        read_reg1 = 5'd12; #1;
        checks++;
        if (read_data1 !== 32'hC0DE0012) begin
            errors++; $display("FAIL b2b_r12: got %h expected %h", read_data1, 32'hC0DE0012);
        end
        checks++;
        if (commit_count !== 32'd9) begin
            errors++; $display("FAIL b2b_count: got %h expected %h", commit_count, 32'd9);
        end
    endtask

    task automatic test_saturation;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sat_count !== 3'd0) begin
            errors++; $display("FAIL sat_reset: got %h expected %h", sat_count, 3'd0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 9; i++) begin
            do_write(1'b0, 5'(i + 14), 32'h0, 32'(i));
            if (i == 6) begin
                checks++;
                if (sat_count !== 3'd6) begin
                    errors++; $display("FAIL sat_six: got %h expected %h", sat_count, 3'd6);
                end
            end
            if (i == 7) begin
                checks++;
                if (sat_count !== 3'd7) begin
                    errors++; $display("FAIL sat_seven: got %h expected %h", sat_count, 3'd7);
                end
            end
        end
        checks++;
        if (sat_count !== 3'd7) begin
            errors++; $display("FAIL sat_hold: got %h expected %h", sat_count, 3'd7);
        end
        checks++;
        if (commit_count !== 32'd9) begin
            errors++; $display("FAIL sat_wide_count: got %h expected %h", commit_count, 32'd9);
        end
    endtask

    initial begin
        test_reset;
        test_mux_commit;
        test_zero_reg;
        test_dual_read;
        test_hazard;
        test_back_to_back;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
